// File: rtl/state_down_seq_pkg.sv
// Shared state encoding for the mod-15 up/down sequencers.
// STATE_DOWN_SEQ_ONEHOT_EN adds the one-hot decode helper.
package state_down_seq_pkg;

    localparam int WIDTH    = 4;
    localparam int LAST_IDX = 14;
    localparam logic [WIDTH-1:0] LAST_STATE = WIDTH'(LAST_IDX);

    typedef enum logic [WIDTH-1:0] {
        S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3,  S4  = 4'd4,
        S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7,  S8  = 4'd8,  S9  = 4'd9,
        S10 = 4'd10, S11 = 4'd11, S12 = 4'd12, S13 = 4'd13, S14 = 4'd14
    } seqState_e;

`ifdef STATE_DOWN_SEQ_ONEHOT_EN
    function automatic logic [LAST_IDX:0] decodeOneHot(input logic [WIDTH-1:0] state);
        logic [LAST_IDX:0] result;
        result = '0;
        if (state <= LAST_STATE) begin
            result[state] = 1'b1;
        end
        return result;
    endfunction
`endif

endpackage

// File: rtl/state_down_seq_prevstate.sv
// Combinational predecessor map: S(n) -> S(n-1), S0 and out-of-range codes -> LAST_STATE.
module state_down_seq_prevstate
    import state_down_seq_pkg::*;
(
    input  logic [WIDTH-1:0] CurrentState_i,
    output logic [WIDTH-1:0] PrevState_o
);

    always_comb begin
        PrevState_o = LAST_STATE;
        case (CurrentState_i)
            S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13, S14:
                PrevState_o = CurrentState_i - WIDTH'(1);
            default:
                PrevState_o = LAST_STATE;
        endcase
    end

endmodule

// File: rtl/state_down_seq.sv
// Registered mod-15 down-sequencer with parallel load, wrap borrow and sticky illegal-load flag.
// STATE_DOWN_SEQ_ONEHOT_EN adds the registered OneHot_o decode.
module state_down_seq
    import state_down_seq_pkg::*;
(
    input  logic                Clk_i,
    input  logic                Rst_i,
    input  logic                Enable_i,
    input  logic                Load_i,
    input  logic [WIDTH-1:0]    LoadState_i,
    output logic [WIDTH-1:0]    CurrentState_o,
    output logic [WIDTH-1:0]    PrevState_o,
    output logic                Borrow_o,
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
    output logic [LAST_IDX:0]   OneHot_o,
`endif
    output logic                IllegalLoad_o
);

    logic [WIDTH-1:0] prevState;

    state_down_seq_prevstate uPrevState (
        .CurrentState_i (CurrentState_o),
        .PrevState_o    (prevState)
    );

    assign PrevState_o = prevState;

    // Control is level-sampled each edge, no handshake: Rst_i beats Load_i beats
    // Enable_i; Borrow_o marks only a stepped S0 -> LAST_STATE wrap.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            CurrentState_o <= LAST_STATE;
            Borrow_o       <= 1'b0;
            IllegalLoad_o  <= 1'b0;
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
            OneHot_o       <= decodeOneHot(LAST_STATE);
`endif
        end else begin
            Borrow_o <= 1'b0;
            if (Load_i) begin
                if (LoadState_i > LAST_STATE) begin
                    CurrentState_o <= LAST_STATE;
                    IllegalLoad_o  <= 1'b1;
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
                    OneHot_o       <= decodeOneHot(LAST_STATE);
`endif
                end else begin
                    CurrentState_o <= LoadState_i;
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
                    OneHot_o       <= decodeOneHot(LoadState_i);
`endif
                end
            end else if (Enable_i) begin
                CurrentState_o <= prevState;
                Borrow_o       <= (CurrentState_o == S0);
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
                OneHot_o       <= decodeOneHot(prevState);
`endif
            end
        end
    end

endmodule

// File: tb/tb_state_down_seq.sv
// Directed plus random stimulus for state_down_seq with a queued expected-value scoreboard.
module tb_state_down_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic [3:0]  ldState = 4'd0;
    logic [3:0]  cur;
    logic [3:0]  prev;
    logic        borrow;
    logic        illegal;
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
    logic [14:0] oneHot;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] mCur = 4'd14;
    logic       mBorrow = 1'b0;
    logic       mIll = 1'b0;

    // Packed expectation: {state, prevState, borrow, illegal}
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    state_down_seq dut (
        .Clk_i          (clk),
        .Rst_i          (rst),
        .Enable_i       (en),
        .Load_i         (ld),
        .LoadState_i    (ldState),
        .CurrentState_o (cur),
        .PrevState_o    (prev),
        .Borrow_o       (borrow),
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
        .OneHot_o       (oneHot),
`endif
        .IllegalLoad_o  (illegal)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStep(input logic r, input logic l, input logic e, input logic [3:0] v);
        logic [9:0] expVec;
        logic [3:0] expPrev;
        rst = r;
        ld = l;
        en = e;
        ldState = v;
        if (r) begin
            mCur = 4'd14;
            mBorrow = 1'b0;
            mIll = 1'b0;
        end else begin
            mBorrow = 1'b0;
            if (l) begin
                if (v > 4'd14) begin
                    mCur = 4'd14;
                    mIll = 1'b1;
                end else begin
                    mCur = v;
                end
            end else if (e) begin
                mBorrow = (mCur == 4'd0);
                mCur = (mCur == 4'd0) ? 4'd14 : mCur - 4'd1;
            end
        end
        expPrev = (mCur == 4'd0) ? 4'd14 : mCur - 4'd1;
        exp_q.push_back({mCur, expPrev, mBorrow, mIll});
        @(posedge clk);
        #1;
        expVec = exp_q.pop_front();
        check("state", 16'(cur), 16'(expVec[9:6]));
        check("prevState", 16'(prev), 16'(expVec[5:2]));
        check("borrow", 16'(borrow), 16'(expVec[1]));
        check("illegalLoad", 16'(illegal), 16'(expVec[0]));
`ifdef STATE_DOWN_SEQ_ONEHOT_EN
        check("oneHot", 16'(oneHot), 16'(15'd1 << expVec[9:6]));
`endif
    endtask

    initial begin
        // Reset and a full enabled lap past the wrap
        applyStep(1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) applyStep(1'b0, 1'b0, 1'b1, 4'd0);

        // Legal load then two steps
        applyStep(1'b0, 1'b1, 1'b0, 4'd5);
        applyStep(1'b0, 1'b0, 1'b1, 4'd0);
        applyStep(1'b0, 1'b0, 1'b1, 4'd0);

        // Illegal load, sticky across a legal load, cleared by reset
        applyStep(1'b0, 1'b1, 1'b0, 4'd15);
        applyStep(1'b0, 1'b1, 1'b0, 4'd3);
        applyStep(1'b0, 1'b0, 1'b0, 4'd0);
        applyStep(1'b1, 1'b0, 1'b0, 4'd0);

        // Load beats enable at S0: no borrow; then a real wrap from S0
        applyStep(1'b0, 1'b1, 1'b0, 4'd0);
        applyStep(1'b0, 1'b1, 1'b1, 4'd14);
        applyStep(1'b0, 1'b1, 1'b0, 4'd0);
        applyStep(1'b0, 1'b0, 1'b1, 4'd0);
        applyStep(1'b0, 1'b0, 1'b0, 4'd0);
        applyStep(1'b0, 1'b1, 1'b0, 4'd14);

        // Reset beats load at S7, with a sticky flag set beforehand
        applyStep(1'b0, 1'b1, 1'b0, 4'd15);
        applyStep(1'b0, 1'b1, 1'b0, 4'd7);
        applyStep(1'b1, 1'b1, 1'b1, 4'd2);

        // Hold at state 9
        applyStep(1'b0, 1'b1, 1'b0, 4'd9);
        for (int i = 0; i < 3; i++) applyStep(1'b0, 1'b0, 1'b0, 4'd0);

        // Random tail
        for (int i = 0; i < 60; i++) begin
            applyStep(($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) != 0),
                      4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
